// File: rtl/lut_layer_pkg.sv
// Shared types, sizing constants and table-index helper for the LUT layer sequencer.
package lut_layer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } lut_seq_state_t;

    localparam int unsigned NUM_NEURONS_DEF = 64;
    localparam int unsigned IN_BITS_DEF     = 7;
    localparam int unsigned OUT_BITS_DEF    = 2;
    localparam int unsigned TABLE_DEPTH     = NUM_NEURONS_DEF << IN_BITS_DEF;
    localparam int unsigned FRAME_CNT_W     = 16;

    // Each neuron owns a contiguous 2^in_bits slice of the shared table.
    function automatic int unsigned table_index(input int unsigned neuron,
                                                input int unsigned addr,
                                                input int unsigned in_bits);
        return (neuron << in_bits) | addr;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Shared truth-table store: one write port, one registered read port, no reset.
module lut_table_ram #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Block-RAM style write and one-cycle read; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer evaluator walking every neuron through one shared table RAM.
module lut_layer_sequencer
    import lut_layer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int unsigned IN_BITS     = IN_BITS_DEF,
    parameter int unsigned OUT_BITS    = OUT_BITS_DEF,
    parameter int unsigned NIDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    output logic                            cfg_ready,
    input  logic [NIDX_W-1:0]               cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic                            busy,
    output logic [FRAME_CNT_W-1:0]          frame_count
);

    localparam int unsigned     TBL_AW       = NIDX_W + IN_BITS;
    localparam int unsigned     TBL_DEPTH    = NUM_NEURONS << IN_BITS;
    // One extra bit so the range check stays meaningful when NUM_NEURONS is a power of two.
    localparam logic [NIDX_W:0] NEURON_LIMIT = (NIDX_W + 1)'(NUM_NEURONS);
    localparam logic [NIDX_W-1:0] LAST_IDX   = NIDX_W'(NUM_NEURONS - 1);

    lut_seq_state_t state_q, state_d;

    logic [NIDX_W-1:0]               idx_q, idx_d;
    logic [NUM_NEURONS*IN_BITS-1:0]  addr_q, addr_d;
    logic                            cap_pend_q, cap_pend_d;
    logic [NIDX_W-1:0]               cap_idx_q, cap_idx_d;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic [FRAME_CNT_W-1:0]          frame_cnt_q, frame_cnt_d;

    logic                rd_en;
    logic [IN_BITS-1:0]  cur_addr;
    logic [TBL_AW-1:0]   rd_addr;
    logic [OUT_BITS-1:0] rd_data;
    logic                wr_en;
    logic [TBL_AW-1:0]   wr_addr;

    assign cur_addr = addr_q[idx_q*IN_BITS +: IN_BITS];
    assign rd_addr  = TBL_AW'(table_index(32'(idx_q), 32'(cur_addr), IN_BITS));
    assign wr_addr  = TBL_AW'(table_index(32'(cfg_neuron), 32'(cfg_addr), IN_BITS));

    // Table writes only land while idle; out-of-range neurons are silently dropped.
    assign wr_en = cfg_we && (state_q == IDLE) && ({1'b0, cfg_neuron} < NEURON_LIMIT);

    lut_table_ram #(
        .DEPTH (TBL_DEPTH),
        .WIDTH (OUT_BITS),
        .AW    (TBL_AW)
    ) u_table (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (cfg_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Sequencing FSM: next state, neuron walk, handshakes and frame counter.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        cap_pend_d  = 1'b0;
        cap_idx_d   = cap_idx_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        out_valid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) begin
                    addr_d  = in_addr;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_en      = 1'b1;
                cap_pend_d = 1'b1;
                cap_idx_d  = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                // The final neuron's read result lands in out_data during this cycle.
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drop each read result into its neuron slice one cycle after the read was issued.
    always_comb begin
        out_data_d = out_data_q;
        if (cap_pend_q) begin
            out_data_d[cap_idx_q*OUT_BITS +: OUT_BITS] = rd_data;
        end
    end

    // State and datapath registers; the table RAM is intentionally outside this reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            cap_pend_q  <= 1'b0;
            cap_idx_q   <= '0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            cap_pend_q  <= cap_pend_d;
            cap_idx_q   <= cap_idx_d;
            out_data_q  <= out_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_data    = out_data_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed self-checking bench for lut_layer_sequencer with hand-computed results.
module tb_lut_layer_sequencer;

    localparam int N  = 64;
    localparam int IB = 7;
    localparam int OB = 2;
    localparam int NW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*IB-1:0] in_addr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N*OB-1:0] out_data;
    logic            cfg_we = 1'b0;
    logic            cfg_ready;
    logic [NW-1:0]   cfg_neuron = '0;
    logic [IB-1:0]   cfg_addr = '0;
    logic [OB-1:0]   cfg_data = '0;
    logic            busy;
    logic [15:0]     frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lut_layer_sequencer #(
        .NUM_NEURONS (N),
        .IN_BITS     (IB),
        .OUT_BITS    (OB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cfg_we      (cfg_we),
        .cfg_ready   (cfg_ready),
        .cfg_neuron  (cfg_neuron),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .busy        (busy),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Send one frame, wait (bounded) for the result, then accept it after `hold` stall cycles.
    task automatic run_frame(input logic [N*IB-1:0] vec, input int hold,
                             output logic [127:0] res, output int lat);
        in_addr  = vec;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            cyc();
            lat++;
        end
        res = out_data;
        repeat (hold) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic [N*IB-1:0] vec;
    logic [127:0]    res;
    int              lat;

    initial begin
        // Reset state
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_cfg_ready", 128'(cfg_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_frame_count", 128'(frame_count), 128'(0));

        // Program every table: n0[0x00]=01, n1[0x7F]=11, all else 0
        for (int n = 0; n < N; n++) begin
            for (int a = 0; a < 128; a++) begin
                cfg_we     = 1'b1;
                cfg_neuron = 6'(n);
                cfg_addr   = 7'(a);
                if (n == 0 && a == 0)        cfg_data = 2'b01;
                else if (n == 1 && a == 127) cfg_data = 2'b11;
                else                         cfg_data = 2'b00;
                cyc();
            end
        end
        cfg_we = 1'b0;

        // Frame 1 with inline back-pressure checks
        vec = '0;
        vec[1*IB +: IB] = 7'h7F;
        in_addr  = vec;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("issue_busy", 128'(busy), 128'(1));
        check("issue_in_ready", 128'(in_ready), 128'(0));
        lat = 1;
        while (!out_valid && lat < 200) begin
            cyc();
            lat++;
        end
        check("f1_latency", 128'(lat), 128'(66));
        check("f1_data", out_data, 128'h0000_0000_0000_0000_0000_0000_0000_000D);
        // Stall 20 cycles while offering a different frame that must not be taken
        in_addr  = '1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("hold_data", out_data, 128'hD);
            check("hold_in_ready", 128'(in_ready), 128'(0));
        end
        check("hold_out_valid", 128'(out_valid), 128'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("post_hs_busy", 128'(busy), 128'(0));
        check("post_hs_out_valid", 128'(out_valid), 128'(0));
        check("post_hs_in_ready", 128'(in_ready), 128'(1));
        check("post_hs_count", 128'(frame_count), 128'(1));
        check("post_hs_data_kept", out_data, 128'hD);
        cyc();
        check("stalled_frame_dropped", 128'(busy), 128'(0));

        // Frame 2: table write in the same idle cycle as the frame handshake
        vec = '0;
        vec[5*IB +: IB] = 7'h10;
        cfg_we     = 1'b1;
        cfg_neuron = 6'd5;
        cfg_addr   = 7'h10;
        cfg_data   = 2'b10;
        run_frame(vec, 0, res, lat);
        check("f2_latency", 128'(lat), 128'(66));
        check("f2_data", res, 128'h801);
        check("f2_count", 128'(frame_count), 128'(2));

        // Frame 3: a write attempted mid-ISSUE must be ignored
        in_addr  = vec;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (9) cyc();
        cfg_we     = 1'b1;
        cfg_neuron = 6'd5;
        cfg_addr   = 7'h10;
        cfg_data   = 2'b01;
        check("issue_cfg_ready", 128'(cfg_ready), 128'(0));
        cyc();
        cfg_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            cyc();
            lat++;
        end
        check("f3_data", out_data, 128'h801);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        run_frame(vec, 3, res, lat);
        check("f4_data", res, 128'h801);
        check("f4_count", 128'(frame_count), 128'(4));

        // Reset 30 cycles into a frame; table contents must survive
        vec = '0;
        vec[1*IB +: IB] = 7'h7F;
        vec[5*IB +: IB] = 7'h10;
        in_addr  = vec;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (29) cyc();
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_cfg_ready", 128'(cfg_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out_data", out_data, 128'(0));
        cyc();
        rst = 1'b0;
        repeat (70) cyc();
        // Reset clears the counter and the discarded frame never adds to it
        check("midrst_count", 128'(frame_count), 128'(0));
        check("midrst_no_output", 128'(out_valid), 128'(0));
        run_frame(vec, 0, res, lat);
        check("resend_latency", 128'(lat), 128'(66));
        check("resend_data", res, 128'h80D);
        check("resend_count", 128'(frame_count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
